// File: rtl/incr_arb_pkg.sv
// Shared types and default widths for the incrementing round-robin arbiter.
package incr_arb_pkg;

  localparam int unsigned DEF_WIDTH  = 32;
  localparam int unsigned DEF_STEP_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARB   = 2'd1,
    APPLY = 2'd2
  } state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, with wrap.
module rr_pick #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [IDW-1:0]  idx,
  output logic            found
);

  logic [IDW:0] cand;

  always_comb begin
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      // ptr < NREQ, so a single subtraction folds the candidate back into range
      cand = {1'b0, ptr} + (IDW+1)'(k);
      if (cand >= (IDW+1)'(NREQ)) cand = cand - (IDW+1)'(NREQ);
      if (!found && req[cand[IDW-1:0]]) begin
        found = 1'b1;
        idx   = cand[IDW-1:0];
      end
    end
  end

endmodule

// File: rtl/incr_arbiter.sv
// Round-robin sequencer sharing one incrementing accumulator between NREQ requesters.
// Define INCR_ARB_SATURATE_EN to saturate at all-ones on carry-out instead of wrapping.
module incr_arbiter
  import incr_arb_pkg::*;
#(
  parameter int unsigned NREQ   = 4,
  parameter int unsigned WIDTH  = DEF_WIDTH,
  parameter int unsigned STEP_W = DEF_STEP_W
) (
  input  logic                     clk,
  input  logic                     clr,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*STEP_W-1:0]   step,
  input  logic                     sclr,
  output logic [NREQ-1:0]          gnt,
  output logic [WIDTH-1:0]         value,
  output logic [$clog2(NREQ)-1:0]  last_id,
  output logic                     busy,
  output logic                     ovf
);

  localparam int unsigned IDW = $clog2(NREQ);

  state_e            state_q, state_d;
  logic [IDW-1:0]    ptr_q, ptr_d;
  logic [IDW-1:0]    win_q, win_d;
  logic [IDW-1:0]    last_id_q, last_id_d;
  logic [STEP_W-1:0] wstep_q, wstep_d;
  logic [WIDTH-1:0]  value_q, value_d;
  logic              ovf_q, ovf_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;

  logic [IDW-1:0]    pick;
  logic              found;
  logic [STEP_W-1:0] step_arr [NREQ];
  logic [WIDTH:0]    sum;
  logic [WIDTH-1:0]  applied;

  for (genvar g = 0; g < NREQ; g++) begin : g_step
    assign step_arr[g] = step[g*STEP_W +: STEP_W];
  end

  rr_pick #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_pick (
    .req   (req),
    .ptr   (ptr_q),
    .idx   (pick),
    .found (found)
  );

  assign sum = {1'b0, value_q} + {{(WIDTH+1-STEP_W){1'b0}}, wstep_q};

`ifdef INCR_ARB_SATURATE_EN
  assign applied = sum[WIDTH] ? '1 : sum[WIDTH-1:0];
`else
  assign applied = sum[WIDTH-1:0];
`endif

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    win_d     = win_q;
    last_id_d = last_id_q;
    wstep_d   = wstep_q;
    value_d   = value_q;
    ovf_d     = ovf_q;
    gnt_d     = '0;
    if (sclr) begin
      // Drops any latched winner; ptr and last_id survive
      value_d = '0;
      ovf_d   = 1'b0;
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: if (|req) state_d = ARB;
        ARB: begin
          if (found) begin
            win_d   = pick;
            wstep_d = step_arr[pick];
            state_d = APPLY;
          end else begin
            state_d = IDLE;
          end
        end
        APPLY: begin
          value_d       = applied;
          ovf_d         = ovf_q | sum[WIDTH];
          gnt_d[win_q]  = 1'b1;
          last_id_d     = win_q;
          ptr_d         = (win_q == IDW'(NREQ - 1)) ? '0 : win_q + IDW'(1);
          state_d       = (|req) ? ARB : IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(negedge clk or negedge clr) begin
    if (!clr) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      win_q     <= '0;
      last_id_q <= '0;
      wstep_q   <= '0;
      value_q   <= '0;
      ovf_q     <= 1'b0;
      gnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      win_q     <= win_d;
      last_id_q <= last_id_d;
      wstep_q   <= wstep_d;
      value_q   <= value_d;
      ovf_q     <= ovf_d;
      gnt_q     <= gnt_d;
    end
  end

  assign gnt     = gnt_q;
  assign value   = value_q;
  assign last_id = last_id_q;
  assign busy    = (state_q == ARB) || (state_q == APPLY);
  assign ovf     = ovf_q;

endmodule

// File: tb/tb_incr_arbiter.sv
// Directed bench for incr_arbiter; a second 8-bit instance shares stimulus to reach carry-out.
module tb_incr_arbiter;

  logic        clk;
  logic        clr;
  logic        sclr;
  logic [3:0]  req;
  logic [31:0] step;
  logic [3:0]  gnt, gnt_n;
  logic [31:0] value;
  logic [7:0]  value_n;
  logic [1:0]  last_id, last_id_n;
  logic        busy, busy_n, ovf, ovf_n;

  int n_tests = 0;
  int n_fail  = 0;

  int fair_id  [5] = '{0, 1, 2, 3, 0};
  int fair_val [5] = '{1, 3, 6, 10, 11};
  logic [3:0]  exp_g;
  logic [31:0] exp_n1, exp_n2;

  incr_arbiter #(.NREQ(4), .WIDTH(32), .STEP_W(8)) dut (
    .clk     (clk),
    .clr     (clr),
    .req     (req),
    .step    (step),
    .sclr    (sclr),
    .gnt     (gnt),
    .value   (value),
    .last_id (last_id),
    .busy    (busy),
    .ovf     (ovf)
  );

  incr_arbiter #(.NREQ(4), .WIDTH(8), .STEP_W(8)) dut_n (
    .clk     (clk),
    .clr     (clr),
    .req     (req),
    .step    (step),
    .sclr    (sclr),
    .gnt     (gnt_n),
    .value   (value_n),
    .last_id (last_id_n),
    .busy    (busy_n),
    .ovf     (ovf_n)
  );

  initial begin
    clk = 1'b1;
    forever #5 clk = ~clk;
  end

  // Registers move on the falling edge; drive and sample 1 time unit after it
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
`ifdef INCR_ARB_SATURATE_EN
    exp_n1 = 32'hFF;
    exp_n2 = 32'hFF;
`else
    exp_n1 = 32'h03;
    exp_n2 = 32'h08;
`endif
    clr = 1'b0; sclr = 1'b0; req = '0; step = '0;
    tick(2);
    check("rst_value", value, 0);
    check("rst_gnt", {28'd0, gnt}, 0);
    check("rst_last_id", {30'd0, last_id}, 0);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_ovf", {31'd0, ovf}, 0);
    clr = 1'b1;
    tick(1);
    check("idle_busy", {31'd0, busy}, 0);

    // Single requester 2, step 3
    req = 4'b0100; step = {8'd0, 8'd3, 8'd0, 8'd0};
    tick(1);
    check("single_arb_busy", {31'd0, busy}, 1);
    tick(1);
    check("single_no_early_gnt", {28'd0, gnt}, 0);
    check("single_no_early_value", value, 0);
    tick(1);
    check("single_gnt", {28'd0, gnt}, 32'h4);
    check("single_value", value, 3);
    check("single_last_id", {30'd0, last_id}, 2);
    tick(1);
    check("single_gnt_one_cycle", {28'd0, gnt}, 0);
    tick(5);
    check("single_gnt4", {28'd0, gnt}, 32'h4);
    check("single_value12", value, 12);
    req = '0;
    tick(1);
    check("arb_drop_idle", {31'd0, busy}, 0);
    check("arb_drop_value", value, 12);

    // Sync clear in idle keeps last_id
    sclr = 1'b1;
    tick(1);
    sclr = 1'b0;
    check("sclr_idle_value", value, 0);
    check("sclr_idle_last_id", {30'd0, last_id}, 2);

    // Reset while in APPLY with value 9
    req = 4'b0100;
    tick(3);
    check("pre_rst_value3", value, 3);
    tick(4);
    check("pre_rst_value9", value, 9);
    tick(1);
    check("pre_rst_busy", {31'd0, busy}, 1);
    clr = 1'b0;
    #1;
    check("rst_async_value", value, 0);
    check("rst_async_gnt", {28'd0, gnt}, 0);
    check("rst_async_busy", {31'd0, busy}, 0);
    check("rst_async_busy_n", {31'd0, busy_n}, 0);
    check("rst_async_ovf", {31'd0, ovf}, 0);
    check("rst_async_last_id", {30'd0, last_id}, 0);
    req = '0;
    tick(1);
    check("rst_hold_gnt", {28'd0, gnt}, 0);
    clr = 1'b1;
    tick(1);

    // Fairness: all requesters, steps 1..4
    req = 4'hF; step = {8'd4, 8'd3, 8'd2, 8'd1};
    tick(2);
    for (int i = 0; i < 5; i++) begin
      tick(1);
      exp_g = 4'b0001 << fair_id[i];
      check($sformatf("fair_gnt%0d", i), {28'd0, gnt}, {28'd0, exp_g});
      check($sformatf("fair_value%0d", i), value, fair_val[i]);
      check($sformatf("fair_last_id%0d", i), {30'd0, last_id}, fair_id[i]);
      if (i < 4) begin
        tick(1);
        check($sformatf("fair_gap%0d", i), {28'd0, gnt}, 0);
      end
    end
    req = '0;
    tick(1);
    check("fair_idle", {31'd0, busy}, 0);

    // sclr on requester 1's APPLY edge
    req = 4'b0010; step = {8'd0, 8'd0, 8'd6, 8'd0};
    tick(2);
    sclr = 1'b1;
    tick(1);
    check("coll_no_gnt", {28'd0, gnt}, 0);
    check("coll_value", value, 0);
    check("coll_busy", {31'd0, busy}, 0);
    check("coll_last_id", {30'd0, last_id}, 0);
    sclr = 1'b0;
    tick(3);
    check("coll_regrant_gnt", {28'd0, gnt}, 32'h2);
    check("coll_regrant_value", value, 6);
    check("coll_regrant_last_id", {30'd0, last_id}, 1);
    req = '0;
    tick(1);

    // Step change after the ARB edge is ignored
    req = 4'b0001; step = {24'd0, 8'd7};
    tick(2);
    step = {24'd0, 8'd9};
    tick(1);
    check("late_gnt", {28'd0, gnt}, 32'h1);
    check("late_value", value, 13);
    req = '0;
    tick(1);

    // Carry-out: 8-bit instance at 0xFE plus 5
    sclr = 1'b1;
    tick(1);
    sclr = 1'b0;
    check("wrap_clr_n", {24'd0, value_n}, 0);
    req = 4'b0001; step = {24'd0, 8'd254};
    tick(3);
    check("wrap_pre_value", value, 254);
    check("wrap_pre_value_n", {24'd0, value_n}, 32'hFE);
    check("wrap_pre_ovf_n", {31'd0, ovf_n}, 0);
    req = '0;
    tick(1);
    req = 4'b0001; step = {24'd0, 8'd5};
    tick(3);
    check("wrap_value_wide", value, 259);
    check("wrap_ovf_wide", {31'd0, ovf}, 0);
    check("wrap_value_n", {24'd0, value_n}, exp_n1);
    check("wrap_ovf_n", {31'd0, ovf_n}, 1);
    check("wrap_gnt_n", {28'd0, gnt_n}, 32'h1);
    check("wrap_last_id_n", {30'd0, last_id_n}, 0);
    tick(2);
    check("wrap2_value_wide", value, 264);
    check("wrap2_value_n", {24'd0, value_n}, exp_n2);
    check("wrap2_ovf_sticky", {31'd0, ovf_n}, 1);
    check("wrap2_gnt_n", {28'd0, gnt_n}, 32'h1);
    req = '0;
    tick(1);
    sclr = 1'b1;
    tick(1);
    sclr = 1'b0;
    check("sclr_ovf_n", {31'd0, ovf_n}, 0);
    check("sclr_value_n", {24'd0, value_n}, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/incr_arbiter.md
# incr_arbiter

Round-robin arbiter and sequencer that shares one 32-bit incrementing accumulator between `NREQ` requesters. Each requester asks for the shared value to be advanced by its own step. The block grants one requester at a time, applies the step, and acknowledges the winner. It sits in front of the accumulator datapath and is the only writer of the shared value.

## Interface
- `NREQ`, 4: number of requesters (2..8)
- `WIDTH`, 32: accumulator width
- `STEP_W`, 8: width of each requester's step
- `clk`  in  1  clock; all registers update on the falling edge
- `clr`  in  1  reset, asynchronous, active-low
- `req`  in  NREQ  request per requester, level; held until its `gnt` pulse
- `step`  in  NREQ*STEP_W  step per requester; requester i uses bits [i*STEP_W +: STEP_W]
- `sclr`  in  1  synchronous clear of the accumulator, active-high
- `gnt`  out  NREQ  one-hot, one-cycle pulse when requester i's step has been applied
- `value`  out  WIDTH  current accumulator value
- `last_id`  out  $clog2(NREQ)  index of the most recently granted requester
- `busy`  out  1  high in the ARB and APPLY states
- `ovf`  out  1  sticky carry-out flag

## Operation
- FSM states: IDLE, ARB, APPLY.
- IDLE:
  - `req != 0` goes to ARB.
  - Otherwise stays in IDLE.
- ARB:
  - Picks the winner as the first requester with `req` set, searching from `ptr` upward with wrap.
  - Latches the winner's index and step into internal registers.
  - Goes to APPLY.
  - If `req` dropped to 0 in this cycle, goes to IDLE instead.
- APPLY:
  - `value <= value + zero_ext(step_latched)`.
  - Pulses `gnt[winner]` and sets `last_id <= winner`.
  - Sets `ptr <= winner+1`, modulo NREQ.
  - Goes to ARB if any `req` is still set, else IDLE.
  - The granted requester's own `req` counts in that check: it is still high during the `gnt` cycle.
- Requesters must drop `req` on the edge after seeing `gnt`. A `req` still high then is treated as a new request.
- Step is sampled only in ARB. Changing `step` afterwards has no effect on the current grant.
- Arithmetic: WIDTH+1-bit sum.
  - Carry-out sets `ovf`, which stays set until reset or `sclr`.
  - Default behaviour wraps modulo 2^WIDTH.
- `sclr` has priority over everything:
  - On that edge: `value <= 0`, `ovf <= 0`, FSM goes to IDLE.
  - Any latched winner is dropped, with no `gnt` pulse.
  - `ptr` and `last_id` are kept.
- Fairness: with all requesters held high, grants rotate 0,1,2,3,0,...

## Timing
- Reset (`clr` low, asynchronous):
  - `value=0`, `gnt=0`, `last_id=0`, `busy=0`, `ovf=0`, `ptr=0`, FSM in IDLE.
  - The block leaves reset on the first falling edge after `clr` rises.
- Latency:
  - `req` seen in IDLE at edge n.
  - ARB at edge n+1.
  - `gnt` and the new `value` are visible after edge n+2.
- Throughput: one grant per 2 cycles under continuous demand (APPLY→ARB→APPLY).
- `gnt` is registered and exactly one cycle wide. It is never asserted for two requesters at once.
- Reset mid-operation aborts an in-flight grant with no `gnt` pulse. `value` returns to 0 immediately, without waiting for a clock edge.
- `sclr` and a grant in APPLY on the same edge: `sclr` wins, `value=0`, no `gnt`.

## Configuration
- `INCR_ARB_SATURATE_EN` defined:
  - On carry-out, `value` saturates at all-ones instead of wrapping.
  - `ovf` is still set.
  - Later grants leave `value` at all-ones and still pulse `gnt`.
- `INCR_ARB_SATURATE_EN` undefined: modulo wrap, as described under Operation.

## Structure
- Shared package `incr_arb_pkg`:
  - FSM state enum (IDLE, ARB, APPLY).
  - Default widths `WIDTH=32`, `STEP_W=8`.
- One sub-module, `rr_pick`. It is combinational: inputs `req` and `ptr`, outputs winner index and `found`.
- The accumulator register, FSM and flags live in the top module.

## Test plan
- **Reset:** `clr` low mid-APPLY with `value=9` → `value=0` and `gnt=0` immediately; `busy=0` and `ovf=0`.
- **Single requester:** `req[2]=1`, `step[2]=3` → `gnt[2]` pulses 2 edges later, `value=3`, `last_id=2`. Holding `req[2]` for 3 more grants gives `value=12`.
- **Fairness:** all four `req` high, steps 1,2,3,4 → grants 0,1,2,3,0 on every second edge. `value` runs 1,3,6,10,11.
- **Wrap:** `value=32'hFFFFFFFE`, step 5 → `value=3`, `ovf=1`. With `INCR_ARB_SATURATE_EN`: `value=32'hFFFFFFFF`, `ovf=1`.
- **Sync clear collision:** `sclr=1` on the APPLY edge of requester 1 → `value=0`, no `gnt[1]`. Requester 1 is re-granted on a later ARB/APPLY.
- **Late step change:** `step[0]` goes from 7 to 9 after the ARB edge → `value` increases by 7.
